tick_gen_multi: RTL and testbench

Multi-channel, runtime-programmable clock-enable and square-wave generator that replaces fixed single-rate dividers such as the 1 Hz counter. Each of NCH channels divides `clk` by a per-channel divisor held in a register. Each channel produces a one-cycle `tick` strobe for downstream enables and a 50 % duty `clk_out` level for displays and LEDs. It sits between the board clock and the timing consumers (debouncers, display scan, seconds counters).

---
 rtl/tick_gen_pkg.sv | 18 +
 rtl/tick_gen_chan.sv | 65 ++++++
 rtl/tick_gen_multi.sv | 90 +++++++++
 tb/tb_tick_gen_multi.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tick_gen_pkg.sv
// Shared constants and helpers for the multi-channel tick / square-wave generator.
package tick_gen_pkg;

  localparam int unsigned     CNT_W_DEF       = 27;
  localparam longint unsigned CLK_HZ_DEF      = 100_000_000;
  localparam longint unsigned DEFAULT_DIV_DEF = CLK_HZ_DEF / 2;

  // Toggle interval that yields out_hz on clk_out when clocked at clk_hz.
  function automatic longint unsigned hz_to_div(input longint unsigned clk_hz,
                                                input longint unsigned out_hz);
    return clk_hz / (2 * out_hz);
  endfunction

  function automatic int unsigned ch_idx_w(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/tick_gen_chan.sv
// One divider channel: programmable divisor, counter, tick strobe and 50% clk_out.
module tick_gen_chan #(
  parameter int unsigned      CNT_W   = 27,
  parameter logic [CNT_W-1:0] DEF_DIV = '1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  output logic             tick_o,
  output logic             clk_out_o,
  output logic [CNT_W-1:0] div_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  // A write always beats a coincident terminal count: no tick, no toggle.
  always_comb begin
    div_d     = div_q;
    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    if (wr_i) begin
      div_d = wr_div_i;
      cnt_d = '0;
    end else if (div_q == '0) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == div_q - ONE) begin
        cnt_d     = '0;
        clk_out_d = ~clk_out_q;
        tick_d    = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_q     <= DEF_DIV;
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign tick_o    = tick_q;
  assign clk_out_o = clk_out_q;
  assign div_o     = div_q;
  assign cnt_o     = cnt_q;

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel runtime-programmable clock-enable / square-wave generator.
// Optional register readback port is built when TICK_GEN_READBACK_EN is defined.
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter longint unsigned CLK_HZ      = CLK_HZ_DEF,
  parameter int unsigned     NCH         = 4,
  parameter int unsigned     CNT_W       = CNT_W_DEF,
  parameter longint unsigned DEFAULT_DIV = CLK_HZ / 2,
  localparam int unsigned    CHW         = ch_idx_w(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             wr_en,
  input  logic [CHW-1:0]   wr_ch,
  input  logic [CNT_W-1:0] wr_div,
`ifdef TICK_GEN_READBACK_EN
  input  logic [CHW-1:0]   rd_ch,
  output logic [CNT_W-1:0] rd_div,
  output logic [CNT_W-1:0] rd_cnt,
`endif
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   clk_out
);

  // The reset divisor must fit the counter untruncated.
  if ((DEFAULT_DIV >> CNT_W) != 0) begin : g_div_range
    $error("tick_gen_multi: DEFAULT_DIV does not fit in CNT_W bits");
  end

  logic [CNT_W-1:0] div_a [NCH];
  logic [CNT_W-1:0] cnt_a [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    tick_gen_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (CNT_W'(DEFAULT_DIV))
    ) u_chan (
      .clk_i     (clk),
      .reset_i   (reset),
      .en_i      (en),
      .wr_i      (wr_en && (wr_ch == CHW'(i))),
      .wr_div_i  (wr_div),
      .tick_o    (tick[i]),
      .clk_out_o (clk_out[i]),
      .div_o     (div_a[i]),
      .cnt_o     (cnt_a[i])
    );
  end

`ifdef TICK_GEN_READBACK_EN
  logic [CNT_W-1:0] rd_div_q, rd_div_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;

  // Out-of-range channel indices match no entry and read as zero.
  always_comb begin
    rd_div_d = '0;
    rd_cnt_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_ch == CHW'(i)) begin
        rd_div_d = div_a[i];
        rd_cnt_d = cnt_a[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_div_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      rd_div_q <= rd_div_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign rd_div = rd_div_q;
  assign rd_cnt = rd_cnt_q;
`else
  logic unused_ok;
  always_comb begin
    unused_ok = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      unused_ok = unused_ok ^ (^div_a[i]) ^ (^cnt_a[i]);
    end
  end
`endif

endmodule

// File: tb/tb_tick_gen_multi.sv
// Bench for tick_gen_multi: directed plan scenarios plus randomized traffic vs. a reference model.
module tb_tick_gen_multi;

  localparam int NCH    = 3;
  localparam int CNT_W  = 16;
  localparam int DEFDIV = 5;
  localparam int CHW    = 2;

  logic             clk = 1'b0;
  logic             reset, en, wr_en;
  logic [CHW-1:0]   wr_ch;
  logic [CNT_W-1:0] wr_div;
  logic [NCH-1:0]   tick, clk_out;
`ifdef TICK_GEN_READBACK_EN
  logic [CHW-1:0]   rd_ch;
  logic [CNT_W-1:0] rd_div, rd_cnt;
`endif

  tick_gen_multi #(
    .CLK_HZ      (10),
    .NCH         (NCH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFDIV)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_div  (wr_div),
`ifdef TICK_GEN_READBACK_EN
    .rd_ch   (rd_ch),
    .rd_div  (rd_div),
    .rd_cnt  (rd_cnt),
`endif
    .tick    (tick),
    .clk_out (clk_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: each channel counts enabled cycles since its last restart;
  // a tick falls on every multiple of D and the level flips once per completed interval.
  longint m_div  [NCH];
  longint m_ecnt [NCH];
  bit     m_base [NCH];
  bit     m_lvl  [NCH];
  bit     m_tick [NCH];
  longint m_rd_div, m_rd_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint model_cnt(input int c);
    return (m_div[c] == 0) ? 0 : (m_ecnt[c] % m_div[c]);
  endfunction

  task automatic model_edge(input bit r, input bit e, input bit w, input int wc,
                            input int wd, input int rc);
    if (r) begin
      for (int c = 0; c < NCH; c++) begin
        m_div[c] = DEFDIV; m_ecnt[c] = 0; m_base[c] = 0; m_lvl[c] = 0; m_tick[c] = 0;
      end
      m_rd_div = 0;
      m_rd_cnt = 0;
    end else begin
      m_rd_div = (rc < NCH) ? m_div[rc] : 0;
      m_rd_cnt = (rc < NCH) ? model_cnt(rc) : 0;
      for (int c = 0; c < NCH; c++) begin
        if (w && wc == c) begin
          m_div[c]  = wd;
          m_ecnt[c] = 0;
          m_base[c] = m_lvl[c];
          m_tick[c] = 0;
        end else if (e && m_div[c] != 0) begin
          m_ecnt[c]++;
          m_tick[c] = (m_ecnt[c] % m_div[c]) == 0;
          m_lvl[c]  = m_base[c] ^ bit'((m_ecnt[c] / m_div[c]) % 2);
        end else begin
          m_tick[c] = 0;
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit w, input int wc,
                     input int wd, input int rc);
    reset  = r;
    en     = e;
    wr_en  = w;
    wr_ch  = CHW'(wc);
    wr_div = CNT_W'(wd);
`ifdef TICK_GEN_READBACK_EN
    rd_ch  = CHW'(rc);
`endif
    @(posedge clk);
    model_edge(r, e, w, wc, wd, rc);
    #1;
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("tick%0d", c), 64'(tick[c]), 64'(m_tick[c]));
      check($sformatf("clk_out%0d", c), 64'(clk_out[c]), 64'(m_lvl[c]));
    end
`ifdef TICK_GEN_READBACK_EN
    check("rd_div", 64'(rd_div), 64'(m_rd_div));
    check("rd_cnt", 64'(rd_cnt), 64'(m_rd_cnt));
`endif
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc(0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    bit seen;
    reset = 1'b1; en = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
`ifdef TICK_GEN_READBACK_EN
    rd_ch = '0;
`endif

    cyc(1, 0, 0, 0, 0, 0);
    check("reset_tick", 64'(tick), 64'(0));
    check("reset_clk_out", 64'(clk_out), 64'(0));

    // Edges 1..5: all channels at the default divisor tick on edge 5.
    run(5);
    check("plan_tick_e5", 64'(tick), 64'(3'b111));
    check("plan_clk_e5", 64'(clk_out), 64'(3'b111));
    run(1);
    cyc(0, 1, 1, 1, 3, 0);                      // edge 7: ch1 <- 3
    run(3);                                     // edge 10
    check("plan_tick_e10", 64'(tick), 64'(3'b111));
    check("plan_clk0_e10", 64'(clk_out[0]), 64'(0));
    run(3);                                     // edge 13
    check("plan_tick_e13", 64'(tick), 64'(3'b010));
    run(2);                                     // edge 15
    check("plan_tick_e15", 64'(tick), 64'(3'b101));

    // Halt ch0 with its output high, then run it at D = 1.
    cyc(0, 1, 1, 0, 0, 0);
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      cyc(0, 1, 0, 0, 0, 0);
      seen |= tick[0];
    end
    check("halt_no_tick", 64'(seen), 64'(0));
    check("halt_level", 64'(clk_out[0]), 64'(1));
    cyc(0, 1, 1, 0, 1, 0);
    run(1);
    check("d1_tick_a", 64'(tick[0]), 64'(1));
    run(1);
    check("d1_tick_b", 64'(tick[0]), 64'(1));

    // Enable gap on ch2 in mid-count.
    cyc(0, 1, 1, 2, 5, 0);
    run(2);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 0, 0, 0);
      check("gap_no_tick", 64'(tick), 64'(0));
    end
    run(6);

    // Write on the terminal-count cycle of ch2.
    cyc(0, 1, 1, 2, 3, 0);
    run(2);
    cyc(0, 1, 1, 2, 4, 0);
    check("tc_write_no_tick", 64'(tick[2]), 64'(0));
    run(5);

    // Readback after a write, and of an out-of-range channel.
    cyc(0, 1, 1, 1, 3, 1);
    cyc(0, 1, 0, 0, 0, 1);
`ifdef TICK_GEN_READBACK_EN
    check("rb_ch1_div", 64'(rd_div), 64'(3));
`endif
    cyc(0, 1, 0, 0, 0, 3);
`ifdef TICK_GEN_READBACK_EN
    check("rb_oor_div", 64'(rd_div), 64'(0));
`endif

    // Reset in mid-count restores defaults.
    run(2);
    cyc(1, 1, 0, 0, 0, 0);
    check("midreset_tick", 64'(tick), 64'(0));
    check("midreset_clk", 64'(clk_out), 64'(0));
    run(5);
    check("midreset_default_div", 64'(tick), 64'(3'b111));

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 19) == 0),
          int'($urandom_range(0, 3)),
          int'($urandom_range(0, 9)),
          int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
